// File: rtl/pid_relock_monitor.sv
// pid_relock_monitor: block-averaging conditioner for the lock-indicator ADC channel.
// It sums signed 14-bit samples over a window of 2^N accepted samples. At the end of each
// window it emits the floor mean as a 12-bit offset-binary value for the relock window compare.
// Optional build macro RELOCK_MON_PEAK_EN adds the per-window raw min/max outputs.
// When the macro is undefined, min_o and max_o read 12'h000.
module pid_relock_monitor #(
  parameter int AVG_MAX_LOG2 = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [13:0] adc_i,
  input  logic        adc_vld_i,
  input  logic [3:0]  avg_log2_i,
  input  logic        freeze_i,
  output logic [11:0] signal_o,
  output logic        valid_o,
  output logic [11:0] min_o,
  output logic [11:0] max_o
);
  localparam int AW = 14 + AVG_MAX_LOG2;
  localparam int CW = AVG_MAX_LOG2 + 1;

  // signed 14-bit -> offset binary, top 12 bits
  function automatic logic [11:0] to_ob(input logic [13:0] x);
    return {~x[13], x[12:2]};
  endfunction

  logic [3:0]          n_cl, n_q, nsh_q;
  logic                n_chg, accept, win_end, done_q;
  logic signed [AW-1:0] acc_q, acc_nxt, sum_q, mean;
  logic [CW-1:0]       cnt_q, cnt_nxt;

  // clamp window exponent, detect changes, and form the next accumulator/counter values
  always_comb begin
    n_cl    = (avg_log2_i > 4'(AVG_MAX_LOG2)) ? 4'(AVG_MAX_LOG2) : avg_log2_i;
    n_chg   = (n_cl != n_q);
    accept  = adc_vld_i && !freeze_i && !n_chg;
    acc_nxt = acc_q + AW'($signed(adc_i));
    cnt_nxt = cnt_q + CW'(1);
    win_end = accept && (cnt_nxt == (CW'(1) << n_q));
    mean    = sum_q >>> nsh_q;
  end

  // accumulate; a closing sample captures the full sum and restarts the window on the same edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      n_q    <= '0;
      nsh_q  <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      sum_q  <= '0;
      done_q <= 1'b0;
    end else begin
      n_q    <= n_cl;
      done_q <= 1'b0;
      if (n_chg) begin
        // partial window under the old exponent is thrown away
        acc_q <= '0;
        cnt_q <= '0;
      end else if (accept) begin
        if (win_end) begin
          acc_q  <= '0;
          cnt_q  <= '0;
          sum_q  <= acc_nxt;
          nsh_q  <= n_q;
          done_q <= 1'b1;
        end else begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_nxt;
        end
      end
    end
  end

  // second stage: shift to mean, convert, and strobe valid
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      signal_o <= 12'h800;
      valid_o  <= 1'b0;
    end else begin
      valid_o <= done_q;
      if (done_q) signal_o <= to_ob(mean[13:0]);
    end
  end

`ifdef RELOCK_MON_PEAK_EN
  logic signed [13:0] mn_q, mx_q, mn_nxt, mx_nxt, mnw_q, mxw_q;

  // first accepted sample of a window seeds the running extremes
  always_comb begin
    mn_nxt = (cnt_q == '0 || $signed(adc_i) < mn_q) ? $signed(adc_i) : mn_q;
    mx_nxt = (cnt_q == '0 || $signed(adc_i) > mx_q) ? $signed(adc_i) : mx_q;
  end

  // track extremes, snapshot at window close, publish alongside signal_o
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mn_q  <= '0;
      mx_q  <= '0;
      mnw_q <= '0;
      mxw_q <= '0;
      min_o <= 12'h000;
      max_o <= 12'h000;
    end else begin
      if (accept) begin
        mn_q <= mn_nxt;
        mx_q <= mx_nxt;
        if (win_end) begin
          mnw_q <= mn_nxt;
          mxw_q <= mx_nxt;
        end
      end
      if (done_q) begin
        min_o <= to_ob(mnw_q);
        max_o <= to_ob(mxw_q);
      end
    end
  end
`else
  assign min_o = 12'h000;
  assign max_o = 12'h000;
`endif

endmodule

// File: tb/tb_pid_relock_monitor.sv
// Bench for pid_relock_monitor. A queue-based window model computes the floor mean and the extremes,
// and the bench checks them against the design one cycle later.
module tb_pid_relock_monitor;
  logic        clk_i = 1'b0;
  logic        rst_i, adc_vld_i, freeze_i;
  logic [13:0] adc_i;
  logic [3:0]  avg_log2_i;
  logic [11:0] signal_o, min_o, max_o;
  logic        valid_o;

  pid_relock_monitor dut (
    .clk_i(clk_i), .rst_i(rst_i), .adc_i(adc_i), .adc_vld_i(adc_vld_i),
    .avg_log2_i(avg_log2_i), .freeze_i(freeze_i), .signal_o(signal_o),
    .valid_o(valid_o), .min_o(min_o), .max_o(max_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // reference model state
  int win[$];
  int nq_m = 0;
  bit pend_v = 0;
  int pend_s, pend_mn, pend_mx;
  bit exp_v = 0;
  int exp_s = 'h800, exp_mn = 0, exp_mx = 0;

  function automatic int ob(int v);
    return (v + 8192) >>> 2;
  endfunction

  function automatic int floor_div(int s, int d);
    if (s >= 0) return s / d;
    return -((-s + d - 1) / d);
  endfunction

  // drive one cycle, advance the model, then settle past the edge
  task automatic cyc(bit r, bit v, int a, int n, bit f);
    int nc, sum, mn, mx;
    rst_i = r; adc_vld_i = v; adc_i = 14'(a); avg_log2_i = 4'(n); freeze_i = f;
    @(posedge clk_i);
    exp_v = pend_v;
    if (pend_v) begin exp_s = pend_s; exp_mn = pend_mn; exp_mx = pend_mx; end
    pend_v = 0;
    if (r) begin
      win.delete(); nq_m = 0; exp_v = 0; exp_s = 'h800; exp_mn = 0; exp_mx = 0;
    end else begin
      nc = (n > 10) ? 10 : n;
      if (nc != nq_m) begin
        win.delete(); nq_m = nc;
      end else if (v && !f) begin
        win.push_back(a);
        if (win.size() == (1 << nq_m)) begin
          sum = 0; mn = win[0]; mx = win[0];
          foreach (win[i]) begin
            sum += win[i];
            if (win[i] < mn) mn = win[i];
            if (win[i] > mx) mx = win[i];
          end
          pend_v = 1;
          pend_s = ob(floor_div(sum, 1 << nq_m));
`ifdef RELOCK_MON_PEAK_EN
          pend_mn = ob(mn); pend_mx = ob(mx);
`else
          pend_mn = 0; pend_mx = 0;
`endif
          win.delete();
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cyc(1, 1, 1234, 5, 0);
    total++;
    if (signal_o !== 12'h800 || valid_o !== 1'b0 || min_o !== 12'h000 || max_o !== 12'h000) begin
      bad++; $display("FAIL reset: got s=%h v=%b mn=%h mx=%h want 800 0 000 000", signal_o, valid_o, min_o, max_o);
    end
    cyc(0, 0, 0, 0, 0);
    total++;
    if (signal_o !== 12'h800 || valid_o !== 1'b0) begin
      bad++; $display("FAIL reset_release: got s=%h v=%b want 800 0", signal_o, valid_o);
    end
  endtask

  task automatic test_average();
    int smp[4] = '{100, 200, 300, 400};
    int nv = 0;
    cyc(0, 0, 0, 2, 0);
    foreach (smp[i]) begin
      cyc(0, 1, smp[i], 2, 0);
      total++;
      if (valid_o !== 1'b0) begin bad++; $display("FAIL avg_early_valid: got %b want 0", valid_o); end
    end
    cyc(0, 0, 0, 2, 0);
    total++;
    if (valid_o !== 1'b1 || signal_o !== 12'h83E || signal_o !== 12'(exp_s)) begin
      bad++; $display("FAIL avg_mean: got v=%b s=%h want v=1 s=83E", valid_o, signal_o);
    end
    for (int i = 0; i < 3; i++) begin cyc(0, 0, 0, 2, 0); nv += valid_o; end
    total++;
    if (nv != 0) begin bad++; $display("FAIL avg_trailing_valid: got %0d want 0", nv); end
  endtask

  task automatic test_negative();
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, -3, 1, 0);
    cyc(0, 1, -4, 1, 0);
    cyc(0, 0, 0, 1, 0);
    total++;
    if (valid_o !== 1'b1 || signal_o !== 12'h7FF) begin
      bad++; $display("FAIL neg_floor: got v=%b s=%h want v=1 s=7FF", valid_o, signal_o);
    end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 8191, 0, 0);
    cyc(0, 1, -8192, 0, 0);
    total++;
    if (valid_o !== 1'b1 || signal_o !== 12'hFFF) begin
      bad++; $display("FAIL extreme_pos: got v=%b s=%h want v=1 s=FFF", valid_o, signal_o);
    end
    cyc(0, 0, 0, 0, 0);
    total++;
    if (valid_o !== 1'b1 || signal_o !== 12'h000) begin
      bad++; $display("FAIL extreme_neg: got v=%b s=%h want v=1 s=000", valid_o, signal_o);
    end
  endtask

  task automatic test_freeze();
    int nv = 0;
    cyc(0, 0, 0, 2, 0);
    cyc(0, 1, 40, 2, 0); cyc(0, 1, 80, 2, 0);
    for (int i = 0; i < 5; i++) begin cyc(0, 1, 5000, 2, 1); nv += valid_o; end
    cyc(0, 1, -20, 2, 0); nv += valid_o;
    cyc(0, 1, 4, 2, 0);   nv += valid_o;
    cyc(0, 0, 0, 2, 0);   nv += valid_o;
    total++;
    if (signal_o !== 12'(ob(26)) || signal_o !== 12'(exp_s)) begin
      bad++; $display("FAIL freeze_mean: got s=%h want %h", signal_o, 12'(ob(26)));
    end
    cyc(0, 0, 0, 2, 0); nv += valid_o;
    total++;
    if (nv != 1) begin bad++; $display("FAIL freeze_valid_count: got %0d want 1", nv); end
  endtask

  task automatic test_window_change();
    logic [11:0] held;
    int nv = 0;
    cyc(0, 0, 0, 3, 0);
    held = signal_o;
    for (int i = 0; i < 5; i++) begin cyc(0, 1, 1000 * (i + 1), 3, 0); nv += valid_o; end
    cyc(0, 0, 0, 1, 0); nv += valid_o;
    cyc(0, 1, -100, 1, 0); nv += valid_o;
    total++;
    if (nv != 0 || signal_o !== held) begin
      bad++; $display("FAIL winchg_partial: got nv=%0d s=%h want nv=0 s=%h", nv, signal_o, held);
    end
    cyc(0, 1, -300, 1, 0);
    cyc(0, 0, 0, 1, 0);
    total++;
    if (valid_o !== 1'b1 || signal_o !== 12'(ob(-200))) begin
      bad++; $display("FAIL winchg_new: got v=%b s=%h want v=1 s=%h", valid_o, signal_o, 12'(ob(-200)));
    end
  endtask

  task automatic test_peak();
    int smp[4] = '{-8000, 0, 5, 8000};
    cyc(0, 0, 0, 2, 0);
    foreach (smp[i]) cyc(0, 1, smp[i], 2, 0);
    cyc(0, 0, 0, 2, 0);
    total++;
    if (valid_o !== 1'b1 || min_o !== 12'(exp_mn) || max_o !== 12'(exp_mx)) begin
      bad++; $display("FAIL peak: got v=%b mn=%h mx=%h want v=1 mn=%h mx=%h", valid_o, min_o, max_o, 12'(exp_mn), 12'(exp_mx));
    end
`ifndef RELOCK_MON_PEAK_EN
    total++;
    if (min_o !== 12'h000 || max_o !== 12'h000) begin
      bad++; $display("FAIL peak_off: got mn=%h mx=%h want 000 000", min_o, max_o);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int v;
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      v = int'($urandom_range(0, 16383)) - 8192;
      cyc(0, 1, v, 0, 0);
      if (i > 0) begin
        total++;
        if (valid_o !== 1'b1 || signal_o !== 12'(exp_s)) begin
          bad++; $display("FAIL b2b[%0d]: got v=%b s=%h want v=1 s=%h", i, valid_o, signal_o, 12'(exp_s));
        end
      end
    end
  endtask

  task automatic test_random();
    int n = 2;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 3) n = $urandom_range(0, 15);
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
          int'($urandom_range(0, 16383)) - 8192, n, $urandom_range(0, 9) == 0);
      total++;
      if (valid_o !== exp_v || signal_o !== 12'(exp_s) || min_o !== 12'(exp_mn) || max_o !== 12'(exp_mx)) begin
        bad++;
        $display("FAIL rand[%0d]: got v=%b s=%h mn=%h mx=%h want v=%b s=%h mn=%h mx=%h", i,
                 valid_o, signal_o, min_o, max_o, exp_v, 12'(exp_s), 12'(exp_mn), 12'(exp_mx));
      end
    end
  endtask

  initial begin
    test_reset();
    test_average();
    test_negative();
    test_freeze();
    test_window_change();
    test_peak();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
